// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised 1RW+1R SRAM.
// lane_merge builds a write-first word from an old word, a new word and a
// byte-lane mask; the lane size is passed in as byte_width so one helper
// serves any BYTE_WIDTH the SRAM is built with.
package sram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } sram_state_e;

  // Widest word lane_merge handles; callers size-cast in and out of it.
  localparam int SRAM_MAX_W = 1024;
  localparam int SRAM_IDX_W = $clog2(SRAM_MAX_W);

  function automatic logic [SRAM_MAX_W-1:0] lane_merge(
    input logic [SRAM_MAX_W-1:0] old_w,
    input logic [SRAM_MAX_W-1:0] new_w,
    input logic [SRAM_MAX_W-1:0] mask,
    input int                    byte_width
  );
    logic [SRAM_MAX_W-1:0] res;
    logic [SRAM_IDX_W-1:0] bit_idx;
    logic [SRAM_IDX_W-1:0] lane_idx;
    res = old_w;
    for (int b = 0; b < SRAM_MAX_W; b++) begin
      bit_idx  = SRAM_IDX_W'(b);
      lane_idx = SRAM_IDX_W'(b / byte_width);
      res[bit_idx] = mask[lane_idx] ? new_w[bit_idx] : old_w[bit_idx];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_out_stage.sv
// Optional output register stage: one flop of {valid, data} with sync reset.
module sram_out_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_r;
  logic [W-1:0] data_r;

  // Delay valid and data by one cycle; both clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else begin
      valid_r <= in_valid;
      data_r  <= in_data;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW+1R SRAM: port 0 = LSU (read/write), port 1 = fetch (read).
// After reset a clear FSM zeroes every word before requests are accepted.
// Port 1 reads colliding with a port 0 write see write-first data.
// Optional macro SRAM_OUT_REG_EN adds an output register stage (latency 2).
module sram_1rw1r_param
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int NUM_WMASKS = DATA_WIDTH / BYTE_WIDTH,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision
);

  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

  sram_state_e           state_r;
  sram_state_e           state_nxt_s;
  logic [ADDR_WIDTH-1:0] clr_cnt_r;
  logic [ADDR_WIDTH-1:0] clr_cnt_nxt_s;

  logic [DATA_WIDTH-1:0] mem_r [RAM_DEPTH];

  logic                  ready_s;
  logic                  wr0_s;
  logic                  rd0_s;
  logic                  rd1_s;
  logic                  col_s;
  logic                  wr_en_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s;
  logic [NUM_WMASKS-1:0] wr_mask_s;
  logic [DATA_WIDTH-1:0] rd1_data_s;

  logic [DATA_WIDTH-1:0] dout0_r;
  logic                  dout0_valid_r;
  logic [DATA_WIDTH-1:0] dout1_r;
  logic                  dout1_valid_r;
  logic                  collision_r;

  // Clear FSM next state: walk every address once, then serve requests.
  always_comb begin
    state_nxt_s   = state_r;
    clr_cnt_nxt_s = clr_cnt_r;
    case (state_r)
      ST_INIT: begin
        clr_cnt_nxt_s = clr_cnt_r + CNT_ONE;
        if (clr_cnt_r == CNT_LAST) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_READY: begin
        state_nxt_s = ST_READY;
      end
      default: begin
        state_nxt_s   = ST_INIT;
        clr_cnt_nxt_s = '0;
      end
    endcase
  end

  // Clear FSM state register; reset restarts the clear from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_INIT;
      clr_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      clr_cnt_r <= clr_cnt_nxt_s;
    end
  end

  // Request decode and the single shared write port (clear or port 0 write).
  always_comb begin
    ready_s = (state_r == ST_READY);
    wr0_s   = ready_s && !csb0 && !web0;
    rd0_s   = ready_s && !csb0 && web0;
    rd1_s   = ready_s && !csb1;
    col_s   = wr0_s && rd1_s && (addr0 == addr1) && (wmask0 != '0);
    if (state_r == ST_INIT) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clr_cnt_r;
      wr_data_s = '0;
      wr_mask_s = '1;
    end else begin
      wr_en_s   = wr0_s;
      wr_addr_s = addr0;
      wr_data_s = din0;
      wr_mask_s = wmask0;
    end
  end

  // Port 1 read data: on a collision, written lanes bypass the array.
  always_comb begin
    if (col_s) begin
      rd1_data_s = DATA_WIDTH'(lane_merge(SRAM_MAX_W'(mem_r[addr1]),
                                          SRAM_MAX_W'(din0),
                                          SRAM_MAX_W'(wmask0),
                                          BYTE_WIDTH));
    end else begin
      rd1_data_s = mem_r[addr1];
    end
  end

  // Storage array: one byte-lane write port shared by clear and port 0.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wr_mask_s[i]) begin
          mem_r[wr_addr_s][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data_s[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Read registers: strobes follow each request, data holds while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout0_r       <= '0;
      dout0_valid_r <= 1'b0;
      dout1_r       <= '0;
      dout1_valid_r <= 1'b0;
      collision_r   <= 1'b0;
    end else begin
      dout0_valid_r <= rd0_s;
      dout1_valid_r <= rd1_s;
      collision_r   <= col_s;
      if (rd0_s) begin
        dout0_r <= mem_r[addr0];
      end
      if (rd1_s) begin
        dout1_r <= rd1_data_s;
      end
    end
  end

  assign ready = (state_r == ST_READY);

`ifdef SRAM_OUT_REG_EN
  logic col_valid_s;
  logic col_data_s;

  sram_out_stage #(.W(DATA_WIDTH)) u_stage0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (dout0_valid_r),
    .in_data   (dout0_r),
    .out_valid (dout0_valid),
    .out_data  (dout0)
  );

  sram_out_stage #(.W(DATA_WIDTH)) u_stage1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (dout1_valid_r),
    .in_data   (dout1_r),
    .out_valid (dout1_valid),
    .out_data  (dout1)
  );

  sram_out_stage #(.W(1)) u_stage_col (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (collision_r),
    .in_data   (collision_r),
    .out_valid (col_valid_s),
    .out_data  (col_data_s)
  );

  assign collision = col_valid_s & col_data_s;
`else
  assign dout0       = dout0_r;
  assign dout0_valid = dout0_valid_r;
  assign dout1       = dout1_r;
  assign dout1_valid = dout1_valid_r;
  assign collision   = collision_r;
`endif

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Self-checking bench for sram_1rw1r_param: directed steps plus random traffic
// compared every cycle against a word-array reference model.
module tb_sram_1rw1r_param;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int NW    = 4;
  localparam int DEPTH = 256;
`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ready;
  logic          csb0;
  logic          web0;
  logic [NW-1:0] wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0;
  logic          dout0_valid;
  logic          csb1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] dout1;
  logic          dout1_valid;
  logic          collision;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DW-1:0] mem_m [DEPTH];
  logic          ready_m;
  int            clr_m;
  logic          v0_p [2];
  logic          v1_p [2];
  logic          c_p  [2];
  logic [DW-1:0] d0_p [2];
  logic [DW-1:0] d1_p [2];

  sram_1rw1r_param dut (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .csb0        (csb0),
    .web0        (web0),
    .wmask0      (wmask0),
    .addr0       (addr0),
    .din0        (din0),
    .dout0       (dout0),
    .dout0_valid (dout0_valid),
    .csb1        (csb1),
    .addr1       (addr1),
    .dout1       (dout1),
    .dout1_valid (dout1_valid),
    .collision   (collision)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: update the model from the current inputs, advance, compare.
  task automatic step();
    logic          v0, v1, c;
    logic [DW-1:0] d0, d1;
    v0 = 1'b0; v1 = 1'b0; c = 1'b0;
    d0 = d0_p[0];
    d1 = d1_p[0];
    if (rst) begin
      foreach (mem_m[i]) mem_m[i] = '0;
      clr_m   = 0;
      ready_m = 1'b0;
      d0 = '0;
      d1 = '0;
    end else if (!ready_m) begin
      clr_m++;
      if (clr_m == DEPTH) ready_m = 1'b1;
    end else begin
      if (!csb0 && web0) begin
        v0 = 1'b1;
        d0 = mem_m[addr0];
      end
      if (!csb0 && !web0) begin
        for (int i = 0; i < NW; i++)
          if (wmask0[i]) mem_m[addr0][i*8 +: 8] = din0[i*8 +: 8];
      end
      if (!csb1) begin
        // write-first: port 1 sees the word as it stands after this write
        v1 = 1'b1;
        d1 = mem_m[addr1];
        c  = !csb0 && !web0 && (addr0 == addr1) && (wmask0 != 4'b0000);
      end
    end
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        v0_p[k] = 1'b0; v1_p[k] = 1'b0; c_p[k] = 1'b0;
        d0_p[k] = '0;   d1_p[k] = '0;
      end
    end else begin
      v0_p[1] = v0_p[0]; v1_p[1] = v1_p[0]; c_p[1] = c_p[0];
      d0_p[1] = d0_p[0]; d1_p[1] = d1_p[0];
      v0_p[0] = v0; v1_p[0] = v1; c_p[0] = c;
      d0_p[0] = d0; d1_p[0] = d1;
    end
    @(posedge clk);
    #1;
    chk1("ready", ready, ready_m);
    chk1("dout0_valid", dout0_valid, v0_p[LAT-1]);
    chk1("dout1_valid", dout1_valid, v1_p[LAT-1]);
    chk1("collision", collision, c_p[LAT-1]);
    chk("dout0", dout0, d0_p[LAT-1]);
    chk("dout1", dout1, d1_p[LAT-1]);
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'b0000; addr0 = 8'h00; din0 = 32'h0;
    csb1 = 1'b1; addr1 = 8'h00;
  endtask

  task automatic randomize_inputs();
    csb0   = 1'($urandom);
    web0   = 1'($urandom);
    wmask0 = 4'($urandom);
    addr0  = 8'($urandom_range(0, 7));
    din0   = $urandom;
    csb1   = 1'($urandom);
    addr1  = 8'($urandom_range(0, 7));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      v0_p[k] = 1'b0; v1_p[k] = 1'b0; c_p[k] = 1'b0;
      d0_p[k] = '0;   d1_p[k] = '0;
    end
    foreach (mem_m[i]) mem_m[i] = '0;
    ready_m = 1'b0;
    clr_m   = 0;
    idle();
    rst = 1'b1;

    // 1. reset, clear sequence, ready after exactly DEPTH cycles
    step(); step();
    rst = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      if (k == DEPTH - 1) chk1("ready_before_256", ready, 1'b0);
    end
    chk1("ready_at_256", ready, 1'b1);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h00; csb1 = 1'b0; addr1 = 8'h7F;
    step();
    addr0 = 8'hFF; csb1 = 1'b1;
    step();
    idle();
    for (int k = 0; k < LAT; k++) step();

    // 2. full write then port 0 read
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b1111; addr0 = 8'h10; din0 = 32'hDEADBEEF;
    step();
    idle(); csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h10;
    step();
    idle();
    for (int k = 0; k < LAT - 1; k++) step();
    chk1("t2_valid", dout0_valid, 1'b1);
    chk("t2_dout0", dout0, 32'hDEADBEEF);
    step();
    chk1("t2_valid_drop", dout0_valid, 1'b0);

    // 3. partial write then port 1 read
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b0101; addr0 = 8'h10; din0 = 32'h11223344;
    step();
    idle(); csb1 = 1'b0; addr1 = 8'h10;
    step();
    idle();
    for (int k = 0; k < LAT - 1; k++) step();
    chk("t3_dout1", dout1, 32'hDE22BE44);
    step();

    // 4. same-cycle write/read collision, then a mask-0 write
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b0011; addr0 = 8'h20; din0 = 32'hAABBCCDD;
    csb1 = 1'b0; addr1 = 8'h20;
    step();
    idle();
    for (int k = 0; k < LAT - 1; k++) step();
    chk1("t4_collision", collision, 1'b1);
    chk("t4_dout1", dout1, 32'h0000CCDD);
    step();
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'b0000; addr0 = 8'h20; din0 = 32'h55667788;
    csb1 = 1'b0; addr1 = 8'h20;
    step();
    idle();
    for (int k = 0; k < LAT - 1; k++) step();
    chk1("t4_nocol", collision, 1'b0);
    chk1("t4_nocol_valid", dout1_valid, 1'b1);
    chk("t4_nocol_dout1", dout1, 32'h0000CCDD);
    step();

    // random traffic over a small address window to provoke collisions
    for (int k = 0; k < 400; k++) begin
      randomize_inputs();
      step();
    end

    // 5. reset mid-clear at count 100, then full re-clear
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      randomize_inputs();
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      randomize_inputs();
      step();
    end
    chk1("t5_ready", ready, 1'b1);
    for (int a = 0; a < DEPTH; a++) begin
      idle();
      csb0 = 1'b0; web0 = 1'b1; addr0 = 8'(a);
      csb1 = 1'b0; addr1 = 8'(DEPTH - 1 - a);
      step();
    end
    idle();
    for (int k = 0; k < LAT; k++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
